// File: rtl/nibble_feeder.sv
// nibble_feeder: splits accepted bytes into two nibbles, one per cycle, and
// drives the data/enable inputs of a downstream 4-bit enabled register.
// A downstream hold freezes delivery; a wrapping count of completed bytes is kept.
// Optional build macro: NIBBLE_LSB_FIRST_EN swaps the nibble order (low first).
module nibble_feeder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    input  logic             hold,
    output logic [3:0]       d4,
    output logic             enable,
    output logic             nib_hi,
    output logic             byte_done,
    output logic [CNT_W-1:0] byte_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FIRST  = 2'd1,
        S_SECOND = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;

    logic             accept;
    logic             leave_second;
    logic [3:0]       first_nib;
    logic [3:0]       second_nib;

`ifdef NIBBLE_LSB_FIRST_EN
    assign first_nib  = byte_q[3:0];
    assign second_nib = byte_q[7:4];
`else
    assign first_nib  = byte_q[7:4];
    assign second_nib = byte_q[3:0];
`endif

    // A byte is taken whenever upstream offers and we are ready.
    assign accept       = byte_valid && byte_ready;
    // The second nibble is consumed on any non-held edge in SECOND.
    assign leave_second = (state_q == S_SECOND) && !hold;

    // State register: asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: hold freezes FIRST/SECOND, but IDLE may still accept.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_FIRST;
            end
            S_FIRST: begin
                if (!hold) state_d = S_SECOND;
            end
            S_SECOND: begin
                if (!hold) state_d = accept ? S_FIRST : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: ready also depends on hold in SECOND and is masked in reset.
    always_comb begin
        byte_ready = 1'b0;
        enable     = 1'b0;
        nib_hi     = 1'b0;
        d4         = 4'h0;
        case (state_q)
            S_IDLE: begin
                byte_ready = reset;
            end
            S_FIRST: begin
                enable = !hold;
                nib_hi = 1'b1;
                d4     = first_nib;
            end
            S_SECOND: begin
                byte_ready = reset && !hold;
                enable     = !hold;
                d4         = second_nib;
            end
            default: begin
                byte_ready = 1'b0;
            end
        endcase
    end

    // Datapath next values: byte capture on accept, count and done on completion.
    always_comb begin
        byte_d  = accept ? byte_in : byte_q;
        count_d = leave_second ? (count_q + CNT_W'(1)) : count_q;
        done_d  = leave_second;
    end

    // Byte holder, completed-byte counter and done pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_q  <= 8'h00;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            byte_q  <= byte_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign byte_done  = done_q;
    assign byte_count = count_q;

endmodule
